// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock ratio meter.
package clk_meas_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int unsigned DEF_CNT_W    = 8;
    localparam int unsigned DEF_LOCK_CNT = 3;

    // Width of a counter able to hold 0..lock_cnt.
    function automatic int unsigned match_width(input int unsigned lock_cnt);
        return (lock_cnt < 2) ? 1 : $clog2(lock_cnt + 1);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus a history flop; yields the settled level and a rise pulse.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures the period of a slow input in clk cycles and reports lock once it is stable.
module clock_ratio_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enb,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err
);

    localparam int unsigned        MATCH_W  = match_width(LOCK_CNT);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_CNT);
    localparam logic [MATCH_W-1:0] MATCH_1  = MATCH_W'(1);

    state_t             state;
    logic               sig_level;
    logic               sig_rise;
    logic               rise;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   p;
    logic [CNT_W-1:0]   last_p;
    logic [MATCH_W-1:0] match;
    logic [MATCH_W-1:0] match_nxt;
    logic               timeout;
    logic               same_p;

    sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sig_in),
        .level (sig_level),
        .rise  (sig_rise)
    );

    // The rise pulse is only meaningful while the settled level is high.
    assign rise    = sig_rise & sig_level;
    assign p       = cnt + 1'b1;
    assign timeout = (cnt == CNT_MAX);
    assign same_p  = (p == last_p);

    always_comb begin
        match_nxt = MATCH_1;
        if (same_p && (match != '0)) begin
            match_nxt = match + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enb || rise) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Timeout is tested before the rise so a coincident edge is never sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err          <= 1'b0;
            last_p       <= '0;
            match        <= '0;
        end else begin
            period_valid <= 1'b0;
            err          <= 1'b0;
            if (!enb) begin
                state  <= IDLE;
                match  <= '0;
                locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        locked <= 1'b0;
                        if (rise) begin
                            state <= MEASURE;
                            match <= '0;
                        end
                    end
                    MEASURE: begin
                        if (timeout) begin
                            err    <= 1'b1;
                            state  <= IDLE;
                            match  <= '0;
                            locked <= 1'b0;
                        end else if (rise) begin
                            period       <= p;
                            last_p       <= p;
                            period_valid <= 1'b1;
                            match        <= match_nxt;
                            if (match_nxt == LOCK_TGT) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (timeout) begin
                            err    <= 1'b1;
                            state  <= IDLE;
                            match  <= '0;
                            locked <= 1'b0;
                        end else if (rise) begin
                            period       <= p;
                            period_valid <= 1'b1;
                            if (!same_p) begin
                                err    <= 1'b1;
                                last_p <= p;
                                match  <= MATCH_1;
                                state  <= MEASURE;
                                locked <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        match  <= '0;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Directed bench for clock_ratio_meter with a scoreboard of expected periods.
module tb_clock_ratio_meter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enb;
    logic       sig_in;
    logic [7:0] period;
    logic       period_valid;
    logic       locked;
    logic       err;

    int unsigned total  = 0;
    int unsigned passes = 0;
    int unsigned fails  = 0;

    int cyc = 0;
    int last_rise = 0;
    bit armed = 1'b0;
    int exp_q[$];

    int nvalid = 0;
    int nerr = 0;
    int err_cyc = 0;
    int err_period = 0;
    int err_locked = 0;

    clock_ratio_meter #(.CNT_W(8), .LOCK_CNT(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enb          (enb),
        .sig_in       (sig_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (period_valid) begin
            nvalid++;
            check("valid_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("period", period, exp_q.pop_front());
        end
        if (err) begin
            nerr++;
            err_cyc    = cyc;
            err_period = period;
            err_locked = locked;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a rising edge; the interval since the previous rise is the period the DUT should report.
    task automatic rise_edge(input bit sample);
        sig_in = 1'b1;
        if (sample && armed) exp_q.push_back(cyc - last_rise);
        last_rise = cyc;
        armed = sample;
    endtask

    task automatic gen(input int p, input int n, input bit sample);
        for (int i = 0; i < n; i++) begin
            rise_edge(sample);
            tick(p / 2);
            sig_in = 1'b0;
            tick(p - p / 2);
        end
    endtask

    int v0;
    int e0;

    initial begin
        rst_n = 1'b0;
        enb = 1'b0;
        sig_in = 1'b0;
        tick(3);
        check("rst_period", period, 0);
        check("rst_valid", period_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        enb = 1'b1;
        tick(2);

        // div2: lock appears two edges after the 4th rise is sampled
        gen(2, 3, 1'b1);
        rise_edge(1'b1);
        tick(1);
        sig_in = 1'b0;
        tick(1);
        check("lock_not_yet", locked, 0);
        rise_edge(1'b1);
        tick(1);
        check("lock_at_4th", locked, 1);
        sig_in = 1'b0;
        tick(1);
        gen(2, 5, 1'b1);
        check("div2_no_err", nerr, 0);
        check("div2_locked", locked, 1);

        // div8 relock, then div4 mismatch
        gen(8, 6, 1'b1);
        check("div8_err_cnt", nerr, 1);
        check("div8_err_period", err_period, 8);
        check("div8_locked", locked, 1);
        check("div8_period", period, 8);
        gen(4, 6, 1'b1);
        check("div4_err_cnt", nerr, 2);
        check("div4_err_period", err_period, 4);
        check("div4_err_unlock", err_locked, 0);
        check("div4_relocked", locked, 1);

        // input stops while locked
        e0 = nerr;
        v0 = nvalid;
        for (int i = 0; i < 300 && nerr == e0; i++) tick(1);
        check("timeout_seen", nerr, e0 + 1);
        check("timeout_delay", err_cyc - last_rise, 259);
        check("timeout_unlock", locked, 0);
        check("timeout_hold", period, 4);
        check("timeout_no_valid", nvalid, v0);
        check("timeout_drained", exp_q.size(), 0);
        armed = 1'b0;

        // asynchronous reset while locked
        gen(2, 6, 1'b1);
        tick(4);
        check("pre_rst_locked", locked, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_period", period, 0);
        check("async_rst_locked", locked, 0);
        check("async_rst_valid", period_valid, 0);
        tick(2);
        rst_n = 1'b1;
        armed = 1'b0;
        tick(2);
        v0 = nvalid;
        rise_edge(1'b1);
        tick(1);
        sig_in = 1'b0;
        tick(4);
        check("post_rst_first_rise", nvalid, v0);

        // enb dropped while in MEASURE
        gen(2, 2, 1'b1);
        tick(3);
        check("measure_unlocked", locked, 0);
        enb = 1'b0;
        v0 = nvalid;
        e0 = nerr;
        gen(2, 10, 1'b0);
        tick(4);
        check("enb_low_valid", nvalid, v0);
        check("enb_low_err", nerr, e0);
        check("enb_low_locked", locked, 0);
        enb = 1'b1;
        rise_edge(1'b1);
        tick(2);
        sig_in = 1'b0;
        tick(2);
        check("reenb_first_rise", nvalid, v0);
        gen(4, 6, 1'b1);
        tick(1);
        check("reenb_locked", locked, 1);
        check("reenb_drained", exp_q.size(), 0);

        // rise coincident with cnt == MAX: timeout wins
        tick(last_rise + 256 - cyc);
        v0 = nvalid;
        e0 = nerr;
        rise_edge(1'b0);
        tick(1);
        sig_in = 1'b0;
        tick(4);
        check("coinc_err", nerr, e0 + 1);
        check("coinc_err_time", err_cyc - last_rise, 3);
        check("coinc_no_valid", nvalid, v0);
        check("coinc_unlock", locked, 0);
        gen(2, 5, 1'b1);
        tick(3);
        check("final_locked", locked, 1);
        check("final_err", nerr, e0 + 1);
        check("final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
